// File: rtl/io_result_display_if.sv
// Result/display bundle between the datapath result bus and the 7-segment display pins.
interface io_result_display_if;
  logic [15:0] result;
  logic        result_valid;
  logic [15:0] held;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        dp;

  modport master (output result, result_valid, input held, anode, seg, dp);
  modport slave  (input result, result_valid, output held, anode, seg, dp);
endinterface

// File: rtl/io_result_display.sv
// Captures the datapath result on a valid strobe and scans it as four hex digits
// onto an active-low common-anode 7-segment display. `define RESULT_ZERO_BLANK_EN for leading-zero blanking.
module io_result_display #(
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input logic                CLK,
  input logic                reset,
  io_result_display_if.slave bus
);

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_idx;
  logic [15:0]      held_p0;
  logic [3:0]       nib;
  logic             upper_zero;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [3:0]       anode_p1;
  logic [6:0]       seg_p1;
  logic             dp_p1;

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: hexseg = 7'h40;
      4'h1: hexseg = 7'h79;
      4'h2: hexseg = 7'h24;
      4'h3: hexseg = 7'h30;
      4'h4: hexseg = 7'h19;
      4'h5: hexseg = 7'h12;
      4'h6: hexseg = 7'h02;
      4'h7: hexseg = 7'h78;
      4'h8: hexseg = 7'h00;
      4'h9: hexseg = 7'h10;
      4'hA: hexseg = 7'h08;
      4'hB: hexseg = 7'h03;
      4'hC: hexseg = 7'h46;
      4'hD: hexseg = 7'h21;
      4'hE: hexseg = 7'h06;
      default: hexseg = 7'h0E;
    endcase
  endfunction

  // Digit decode from the pre-edge held value and digit index
  always_comb begin
    nib        = 4'h0;
    upper_zero = 1'b0;
    case (digit_idx)
      2'd0: nib = held_p0[3:0];
      2'd1: begin nib = held_p0[7:4];   upper_zero = (held_p0[15:4]  == 12'h000); end
      2'd2: begin nib = held_p0[11:8];  upper_zero = (held_p0[15:8]  == 8'h00);   end
      default: begin nib = held_p0[15:12]; upper_zero = (held_p0[15:12] == 4'h0); end
    endcase
    seg_nxt = hexseg(nib);
`ifdef RESULT_ZERO_BLANK_EN
    if (upper_zero) seg_nxt = 7'h7F;
`endif
    dp_nxt = !((digit_idx == 2'd0) && (held_p0 != 16'h0000));
  end

  // p0: capture and scan timing; p1: registered display outputs
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      held_p0     <= 16'h0000;
      refresh_cnt <= '0;
      digit_idx   <= 2'd0;
      anode_p1    <= 4'b1111;
      seg_p1      <= 7'h7F;
      dp_p1       <= 1'b1;
    end else begin
      if (bus.result_valid) held_p0 <= bus.result;
      if (refresh_cnt == CNT_W'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        digit_idx   <= digit_idx + 2'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      anode_p1 <= ~(4'b0001 << digit_idx);
      seg_p1   <= seg_nxt;
      dp_p1    <= dp_nxt;
    end
  end

  // Nothing in the design reads upper_zero when blanking is compiled out
  logic unused_ok;
  assign unused_ok = upper_zero;

  assign bus.held  = held_p0;
  assign bus.anode = anode_p1;
  assign bus.seg   = seg_p1;
  assign bus.dp    = dp_p1;

endmodule

// File: tb/tb_io_result_display.sv
// Randomized self-checking bench for io_result_display against a cycle-count based display model.
module tb_io_result_display;
  localparam int RD = 4;

  logic CLK;
  logic reset;
  io_result_display_if bus();

  io_result_display #(.REFRESH_DIV(RD), .CNT_W(16)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors;
  int checks;

  // Model state: value held and number of edges since reset release
  logic [15:0] m_held;
  int          n_edges;
  logic [3:0]  e_anode;
  logic [6:0]  e_seg;
  logic        e_dp;

  logic [6:0] hexrom [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  function automatic logic [6:0] ref_seg(input logic [15:0] h, input int d);
    logic [15:0] upper;
    upper = h >> (4 * d);
`ifdef RESULT_ZERO_BLANK_EN
    if (d > 0 && upper == 16'h0000) return 7'h7F;
`endif
    return hexrom[upper[3:0]];
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held  = 16'h0000;
    n_edges = 0;
    e_anode = 4'b1111;
    e_seg   = 7'h7F;
    e_dp    = 1'b1;
  endtask

  task automatic model_edge();
    int d;
    d       = (n_edges / RD) % 4;
    e_anode = ~(4'b0001 << d);
    e_seg   = ref_seg(m_held, d);
    e_dp    = (d == 0 && m_held != 16'h0000) ? 1'b0 : 1'b1;
    if (bus.result_valid) m_held = bus.result;
    n_edges++;
  endtask

  task automatic compare_outputs();
    chk("held", bus.held, m_held);
    chk("anode", {12'h0, bus.anode}, {12'h0, e_anode});
    chk("seg", {9'h0, bus.seg}, {9'h0, e_seg});
    chk("dp", {15'h0, bus.dp}, {15'h0, e_dp});
    if (!reset) chk("onehot_anode", 16'($countones(~bus.anode)), 16'd1);
  endtask

  // One clock: apply inputs, advance model on the edge, compare on the falling edge
  task automatic cycle(input logic v, input logic [15:0] d);
    bus.result_valid = v;
    bus.result       = d;
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    compare_outputs();
  endtask

  task automatic wait_digit(input int k);
    logic found;
    found = 1'b0;
    cycle(1'b0, 16'h0000);
    for (int i = 0; i < 20 && !found; i++) begin
      if (bus.anode == ~(4'b0001 << k)) found = 1'b1;
      else cycle(1'b0, 16'h0000);
    end
    if (!found) chk("wait_digit", {12'h0, bus.anode}, {12'h0, ~(4'b0001 << k)});
  endtask

  logic [3:0]  seq_an  [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
  logic [6:0]  lit_a5f2 [4] = '{7'h24, 7'h0E, 7'h12, 7'h08};
  logic [6:0]  zdig;
  logic [15:0] r;
  int          nd;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.result_valid = 1'b1;
    bus.result       = 16'hFFFF;
    model_reset();

    #50;
    chk("rst_anode", {12'h0, bus.anode}, 16'h000F);
    chk("rst_seg", {9'h0, bus.seg}, 16'h007F);
    chk("rst_dp", {15'h0, bus.dp}, 16'h0001);
    chk("rst_held", bus.held, 16'h0000);
    #149;
    bus.result_valid = 1'b0;
    reset = 1'b0;
    @(negedge CLK);
    chk("pre_first_edge_anode", {12'h0, bus.anode}, 16'h000F);

    // Free run: each digit selected for exactly RD cycles
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 16'h0000);
      chk("scan_seq", {12'h0, bus.anode}, {12'h0, seq_an[i / RD]});
      if (i == 0) begin
        chk("first_seg", {9'h0, bus.seg}, 16'h0040);
        chk("first_held", bus.held, 16'h0000);
      end
    end

    // 0x0008 single-cycle capture
`ifdef RESULT_ZERO_BLANK_EN
    zdig = 7'h7F;
`else
    zdig = 7'h40;
`endif
    cycle(1'b1, 16'h0008);
    chk("held_0008", bus.held, 16'h0008);
    wait_digit(0);
    chk("d0_seg_0008", {9'h0, bus.seg}, 16'h0000);
    chk("d0_dp_0008", {15'h0, bus.dp}, 16'h0000);
    for (int k = 1; k < 4; k++) begin
      wait_digit(k);
      chk("upper_seg_0008", {9'h0, bus.seg}, {9'h0, zdig});
      chk("upper_dp_0008", {15'h0, bus.dp}, 16'h0001);
    end

    // A5F2 captured on the digit-advance edge
    for (int i = 0; i < 8 && (n_edges % RD) != RD - 1; i++) cycle(1'b0, 16'h0000);
    chk("advance_edge_found", 16'(n_edges % RD), 16'(RD - 1));
    cycle(1'b1, 16'hA5F2);
    chk("held_a5f2", bus.held, 16'hA5F2);
    nd = (n_edges / RD) % 4;
    cycle(1'b0, 16'h0000);
    chk("a5f2_new_digit_anode", {12'h0, bus.anode}, {12'h0, ~(4'b0001 << nd)});
    chk("a5f2_new_digit_seg", {9'h0, bus.seg}, {9'h0, lit_a5f2[nd]});
    for (int k = 0; k < 4; k++) begin
      wait_digit(k);
      chk("a5f2_scan", {9'h0, bus.seg}, {9'h0, lit_a5f2[k]});
    end

    // Back-to-back captures: last one wins
    cycle(1'b1, 16'h1234);
    cycle(1'b1, 16'hBEEF);
    chk("held_beef", bus.held, 16'hBEEF);
    wait_digit(2);
    chk("beef_d2_seg", {9'h0, bus.seg}, 16'h0006);

    // Asynchronous reset mid-scan
    cycle(1'b0, 16'h0000);
    #2;
    reset = 1'b1;
    bus.result_valid = 1'b1;
    bus.result       = 16'h5555;
    #1;
    chk("async_rst_anode", {12'h0, bus.anode}, 16'h000F);
    chk("async_rst_seg", {9'h0, bus.seg}, 16'h007F);
    chk("async_rst_dp", {15'h0, bus.dp}, 16'h0001);
    chk("async_rst_held", bus.held, 16'h0000);
    model_reset();
    #20;
    compare_outputs();
    @(negedge CLK);
    #3;
    bus.result_valid = 1'b0;
    reset = 1'b0;
    cycle(1'b0, 16'h0000);
    chk("post_rst_held", bus.held, 16'h0000);
    chk("post_rst_anode", {12'h0, bus.anode}, 16'h000E);
    chk("post_rst_seg", {9'h0, bus.seg}, 16'h0040);

    // Randomized captures, with shortened values to exercise leading zeros
    for (int i = 0; i < 400; i++) begin
      r = 16'($urandom);
      r = r >> (4 * $urandom_range(0, 4));
      cycle($urandom_range(0, 2) == 0, r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_result_display.md
Name: io_result_display

Overview:
- Output-side counterpart to the datapath's switch/shift/calculate input path.
- Captures the datapath's 16-bit `result` on a one-cycle `result_valid` strobe and holds it.
- Shows the held value as four hex digits on a time-multiplexed, active-low, common-anode 7-segment display.
- Sits between the Datapath `result` bus and the board display pins.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit stays lit before the scan advances; must be ≥2. Benches use 4.
- CNT_W, 16, width of the refresh counter; must satisfy 2^CNT_W ≥ REFRESH_DIV.

Ports:
- CLK  input  1  system clock; rising edge active.
- reset  input  1  asynchronous, active-high reset.
- result  input  16  datapath result word.
- result_valid  input  1  capture strobe; `result` is sampled on any rising edge where this is high.
- held  output  16  currently held (displayed) value.
- anode  output  4  digit enables, active-low; anode[0] is the rightmost digit (result[3:0]).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; see Behaviour.

Behaviour:
- Reset (asynchronous, immediate on assertion):
  - held=16'h0000, refresh counter=0, digit index=0.
  - anode=4'b1111 (all off), seg=7'h7F, dp=1.
- Capture: on a rising edge with result_valid=1, held<=result.
  - Any number of consecutive valid cycles is allowed; the last one wins.
  - held is unchanged when result_valid=0.
- Refresh counter:
  - Increments every cycle from 0 to REFRESH_DIV-1.
  - On the edge where it equals REFRESH_DIV-1, it wraps to 0 and digit index advances 0→1→2→3→0 (mod 4).
- Output stage (registered, one-cycle latency):
  - On every edge: anode <= ~(4'b0001 << digit_idx) and seg <= hexseg(nibble[digit_idx] of held), using pre-edge register values.
  - Consequence: anode/seg first leave reset values on the first edge after reset release, showing digit 0.
  - A new capture appears on seg at most one edge after held updates, while the matching digit is selected.
- Exactly one anode is low at any time after the first post-reset edge. No blanking gap between digits.
- hexseg table (active-low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E
- dp is low only while digit 0 is selected and held ≠ 0, so a nonzero result is flagged. Otherwise dp=1.
- Simultaneous capture and digit advance on the same edge: both take effect. The next edge shows the new held value's nibble for the new digit.
- Reset mid-scan or mid-capture: all state returns to reset values immediately. A result_valid high during reset is ignored.

Optional Feature:
- Macro RESULT_ZERO_BLANK_EN enables leading-zero blanking.
- Defined:
  - For digit k>0, seg is forced to 7'h7F when held[15:4k]==0.
  - The anode still scans normally.
  - Digit 0 is always shown, so held=0 displays "0".
- Undefined: all four digits are always shown, e.g. 0x0008 displays "0008".

Test Plan:
- Reset held 199 ns, then released, no valid → anode=1111, seg=7F, dp=1 during reset. First edge after release gives anode=1110, seg=40. held=0000.
- REFRESH_DIV=4, free-running 20 cycles → anode sequence 1110,1101,1011,0111,1110, each held exactly 4 cycles, no overlap.
- result=16'h0008 with a one-cycle valid → held=0008. Digit 0 shows seg=00 with dp=0. Digits 1–3 show 40 (macro off) or 7F (macro on).
- result=16'hA5F2 with valid on the digit-advance edge → next edge shows the new digit's nibble of A5F2. Full scan reads 24, 0E, 12, 08 on digits 0–3.
- Two consecutive valid cycles with 1234 then BEEF → held=BEEF. Digit 2 shows seg=06.
- Assert reset mid-scan with held=BEEF → outputs go to 1111/7F/1 immediately, without waiting for a clock edge. After release: held=0000 and the scan restarts at digit 0.
